s_cla_pipe: RTL and testbench

S_CLA_PIPE -- requirements
Module: s_cla_pipe

---
 rtl/s_cla_pipe.sv | 110 +++++++++++
 tb/tb_s_cla_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/s_cla_pipe.sv
// rtl/s_cla_pipe.sv - segmented pipelined signed adder/subtractor with ready/valid handshake
// Segment k of the sum is resolved in stage k using the carry registered out of stage k-1.
module s_cla_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic             c_r   [STAGES];
  logic             v_r   [STAGES];
  logic             ovf_r;

  logic [WIDTH-1:0] a_n   [STAGES];
  logic [WIDTH-1:0] b_n   [STAGES];
  logic [WIDTH-1:0] sum_n [STAGES];
  logic             c_n   [STAGES];
  logic             v_n   [STAGES];
  logic             ovf_n;
  logic             en;

  // Resolves segment k of x + y + cin into a copy of sin; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] seg_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [WIDTH-1:0] sin,
                                             input logic cin,
                                             input int k);
    logic [WIDTH-1:0] r;
    logic             c;
    logic             g;
    logic             p;
    r = sin;
    c = cin;
    for (int j = 0; j < SEG; j++) begin
      g = x[k*SEG+j] & y[k*SEG+j];
      p = x[k*SEG+j] ^ y[k*SEG+j];
      r[k*SEG+j] = p ^ c;
      c = g | (p & c);
    end
    return {c, r};
  endfunction

  assign en        = ~v_r[STAGES-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = v_r[STAGES-1];
  assign s         = sum_r[STAGES-1];
  assign co        = c_r[STAGES-1];
  assign ovf       = ovf_r;

  always_comb begin
    a_n[0] = a;
    b_n[0] = op ? ~b : b;
    v_n[0] = in_valid;
    {c_n[0], sum_n[0]} = seg_add(a, op ? ~b : b, '0, op ? ~ci : ci, 0);
    for (int k = 1; k < STAGES; k++) begin
      a_n[k] = a_r[k-1];
      b_n[k] = b_r[k-1];
      v_n[k] = v_r[k-1];
      {c_n[k], sum_n[k]} = seg_add(a_r[k-1], b_r[k-1], sum_r[k-1], c_r[k-1], k);
    end
    // Overflow and saturation are decided where the top segment is resolved.
    ovf_n = (a_n[STAGES-1][WIDTH-1] == b_n[STAGES-1][WIDTH-1]) &&
            (sum_n[STAGES-1][WIDTH-1] != a_n[STAGES-1][WIDTH-1]);
    if (SAT && ovf_n) begin
      sum_n[STAGES-1] = a_n[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
        c_r[k]   <= 1'b0;
        v_r[k]   <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= a_n[k];
        b_r[k]   <= b_n[k];
        sum_r[k] <= sum_n[k];
        c_r[k]   <= c_n[k];
        v_r[k]   <= v_n[k];
      end
      ovf_r <= ovf_n;
    end
  end

endmodule

// File: tb/tb_s_cla_pipe.sv
// tb/tb_s_cla_pipe.sv - directed vector bench for s_cla_pipe (wrapping and saturating instances)
module tb_s_cla_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        op;
  logic [23:0] a;
  logic [23:0] b;
  logic        ci;
  logic        out_ready;
  logic        in_ready_w, in_ready_s;
  logic        out_valid_w, out_valid_s;
  logic [23:0] s_w, s_s;
  logic        co_w, co_s;
  logic        ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  s_cla_pipe #(.WIDTH(24), .STAGES(2), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op(op),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_w), .out_ready(out_ready),
    .s(s_w), .co(co_w), .ovf(ovf_w)
  );

  s_cla_pipe #(.WIDTH(24), .STAGES(2), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_s), .out_ready(out_ready),
    .s(s_s), .co(co_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [23:0] a;
    logic [23:0] b;
    logic        ci;
    logic [23:0] s_wrap;
    logic [23:0] s_sat;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic o, input logic [23:0] x,
                       input logic [23:0] y, input logic c);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
    ci       = c;
  endtask

  initial begin
    tbl[0] = '{1'b0, 24'h000FFF, 24'h000001, 1'b0, 24'h001000, 24'h001000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 24'h7FFFFF, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 24'h000005, 24'h000007, 1'b0, 24'hFFFFFE, 24'hFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 24'h800000, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 24'h000FFF, 24'h000000, 1'b1, 24'h001000, 24'h001000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 24'h800000, 24'hFFFFFF, 1'b0, 24'h7FFFFF, 24'h800000, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 24'h00000A, 24'h000003, 1'b1, 24'h000006, 24'h000006, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 24'h123456, 24'h654321, 1'b0, 24'h777777, 24'h777777, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 24'h000000, 24'h000000, 1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0};

    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid_w}, 32'd0);
    chk("rst_s", {8'b0, s_w}, 32'd0);
    chk("rst_co", {31'b0, co_w}, 32'd0);
    chk("rst_ovf", {31'b0, ovf_w}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_w}, 32'd1);
    step();
    step();
    rst = 1'b0;
    chk("post_rst_out_valid", {31'b0, out_valid_s}, 32'd0);

    // Back-to-back stream: result of vector i appears two edges after it is driven.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci);
      else        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
      step();
      if (i >= 1) begin
        chk($sformatf("v%0d_valid", i-1), {31'b0, out_valid_w}, 32'd1);
        chk($sformatf("v%0d_s_wrap", i-1), {8'b0, s_w}, {8'b0, tbl[i-1].s_wrap});
        chk($sformatf("v%0d_s_sat", i-1), {8'b0, s_s}, {8'b0, tbl[i-1].s_sat});
        chk($sformatf("v%0d_co", i-1), {31'b0, co_w}, {31'b0, tbl[i-1].co});
        chk($sformatf("v%0d_ovf", i-1), {31'b0, ovf_w}, {31'b0, tbl[i-1].ovf});
        chk($sformatf("v%0d_co_sat", i-1), {31'b0, co_s}, {31'b0, tbl[i-1].co});
        chk($sformatf("v%0d_ovf_sat", i-1), {31'b0, ovf_s}, {31'b0, tbl[i-1].ovf});
      end
    end
    step();
    chk("drain_out_valid", {31'b0, out_valid_w}, 32'd0);

    // Backpressure: stall the first result for two edges.
    drive(1'b1, 1'b0, 24'd1, 24'd1, 1'b0);
    step();
    drive(1'b1, 1'b0, 24'd2, 24'd2, 1'b0);
    step();
    chk("bp_first_valid", {31'b0, out_valid_w}, 32'd1);
    chk("bp_first_s", {8'b0, s_w}, 32'd2);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 24'd3, 24'd3, 1'b0);
    #1;
    chk("bp_in_ready_low", {31'b0, in_ready_w}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", i), {31'b0, out_valid_w}, 32'd1);
      chk($sformatf("bp_hold%0d_s", i), {8'b0, s_w}, 32'd2);
      chk($sformatf("bp_hold%0d_in_ready", i), {31'b0, in_ready_w}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'b0, in_ready_w}, 32'd1);
    step();
    drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    chk("bp_second_valid", {31'b0, out_valid_w}, 32'd1);
    chk("bp_second_s", {8'b0, s_w}, 32'd4);
    step();
    chk("bp_third_valid", {31'b0, out_valid_w}, 32'd1);
    chk("bp_third_s", {8'b0, s_w}, 32'd6);
    step();
    chk("bp_empty", {31'b0, out_valid_w}, 32'd0);

    // Reset while beats are in flight.
    drive(1'b1, 1'b0, 24'd5, 24'd5, 1'b0);
    step();
    drive(1'b1, 1'b0, 24'd6, 24'd6, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid_w}, 32'd0);
    chk("mid_rst_s", {8'b0, s_w}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready_w}, 32'd1);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_rst_idle%0d", i), {31'b0, out_valid_w}, 32'd0);
    end
    drive(1'b1, 1'b0, 24'd1, 24'd1, 1'b0);
    step();
    drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    chk("after_rst_latency", {31'b0, out_valid_w}, 32'd0);
    step();
    chk("after_rst_valid", {31'b0, out_valid_w}, 32'd1);
    chk("after_rst_s", {8'b0, s_w}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
